// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, IV, the bit-mixing
// functions, the working-register record and the engine state type.
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  // Working registers a..h; a sits in the top word so the packed layout
  // matches the H0..H7 digest layout (H0 in [255:224]).
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FINAL = 3'd2,
    ST_DONE  = 3'd3
`ifdef SHA256_DOUBLE_EN
    ,
    ST_DBL   = 3'd4
`endif
  } state_e;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // IV flattened into digest layout, H0 in the top word.
  localparam logic [255:0] IV_DIGEST = {IV[0], IV[1], IV[2], IV[3],
                                        IV[4], IV[5], IV[6], IV[7]};

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(word_t x, word_t y, word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(word_t x, word_t y, word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise modulo-2^32 sum of two 8-word vectors (chaining update).
  function automatic logic [255:0] add_words(logic [255:0] x, logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[255-32*i -: 32] = x[255-32*i -: 32] + y[255-32*i -: 32];
    end
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h}, K[t], W[t] -> next {a..h}.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t state_i,
  input  word_t k_i,
  input  word_t w_i,
  output work_t state_o
);

  word_t t1;
  word_t t2;

  assign t1 = state_i.h + bsig1(state_i.e) + ch(state_i.e, state_i.f, state_i.g)
            + k_i + w_i;
  assign t2 = bsig0(state_i.a) + maj(state_i.a, state_i.b, state_i.c);

  assign state_o.a = t1 + t2;
  assign state_o.b = state_i.a;
  assign state_o.c = state_i.b;
  assign state_o.d = state_i.c;
  assign state_o.e = state_i.d + t1;
  assign state_o.f = state_i.e;
  assign state_o.g = state_i.f;
  assign state_o.h = state_i.g;

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression engine, RPC rounds per clock.
// Accepts pre-padded 512-bit blocks, chains multi-block messages through
// the retained H registers and presents the digest over valid/ready.
// Optional double hashing (SHA-256 of the 256-bit digest) is enabled by
// defining SHA256_DOUBLE_EN, which adds the in_dbl port and the DBL state.
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
`ifdef SHA256_DOUBLE_EN
  input  logic         in_dbl,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
    $error("sha256_iter_core: RPC must be 1, 2, 4, 8 or 16");
  end

  // Counter value of the last RUN cycle; the step after it ends the block.
  localparam logic [5:0] LAST_CNT = 6'(64 - RPC);
  localparam logic [5:0] CNT_STEP = 6'(RPC);

  state_e       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  block_t       w_q, w_d;        // schedule window, W[t] in the top word
  work_t        work_q, work_d;
  logic [255:0] h_q, h_d;        // chaining value, H0 in the top word
`ifdef SHA256_DOUBLE_EN
  logic         dbl_q, dbl_d;
`endif

  work_t        round_out;

  // Advance the schedule window by RPC words. New words may depend on
  // words produced earlier in the same step, so they are built in order.
  function automatic block_t next_window(block_t win);
    word_t  ext [0:31];
    block_t res;
    for (int i = 0; i < 32; i++) begin
      ext[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      ext[i] = win[511-32*i -: 32];
    end
    for (int j = 0; j < RPC; j++) begin
      ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
    end
    res = '0;
    for (int i = 0; i < 16; i++) begin
      res[511-32*i -: 32] = ext[i+RPC];
    end
    return res;
  endfunction

  // Chain of RPC rounds; round gi uses K[t+gi] and window word gi.
  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    work_t st_in;
    work_t st_out;
    if (gi == 0) begin : g_head
      assign st_in = work_q;
    end else begin : g_link
      assign st_in = g_round[gi-1].st_out;
    end
    sha256_round u_round (
      .state_i (st_in),
      .k_i     (K[cnt_q + 6'(gi)]),
      .w_i     (w_q[511-32*gi -: 32]),
      .state_o (st_out)
    );
  end

  assign round_out  = g_round[RPC-1].st_out;
  assign out_digest = h_q;

  // Next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_d       = w_q;
    work_d    = work_q;
    h_d       = h_q;
`ifdef SHA256_DOUBLE_EN
    dbl_d     = dbl_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_d   = in_block;
          cnt_d = '0;
          if (in_first) begin
            h_d    = IV_DIGEST;
            work_d = work_t'(IV_DIGEST);
          end else begin
            work_d = work_t'(h_q);
          end
`ifdef SHA256_DOUBLE_EN
          dbl_d = in_dbl;
`endif
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy   = 1'b1;
        work_d = round_out;
        w_d    = next_window(w_q);
        cnt_d  = cnt_q + CNT_STEP;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FINAL;
        end
      end

      ST_FINAL: begin
        busy = 1'b1;
        h_d  = add_words(h_q, 256'(work_q));
`ifdef SHA256_DOUBLE_EN
        state_d = dbl_q ? ST_DBL : ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end

`ifdef SHA256_DOUBLE_EN
      // Second pass hashes the 256-bit first digest as one padded block.
      // busy stays high so the pass boundary is invisible to the feeder.
      ST_DBL: begin
        busy    = 1'b1;
        w_d     = {h_q, 32'h80000000, 192'h0, 32'd256};
        h_d     = IV_DIGEST;
        work_d  = work_t'(IV_DIGEST);
        cnt_d   = '0;
        dbl_d   = 1'b0;
        state_d = ST_RUN;
      end
`endif

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset discards any in-flight block and chaining value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      w_q    <= '0;
      work_q <= work_t'(IV_DIGEST);
      h_q    <= IV_DIGEST;
`ifdef SHA256_DOUBLE_EN
      dbl_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      work_q <= work_d;
      h_q    <= h_d;
`ifdef SHA256_DOUBLE_EN
      dbl_q  <= dbl_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_iter_core.sv
// Testbench for sha256_iter_core: known-answer blocks, chaining, backpressure,
// mid-run reset and random blocks against a behavioural SHA-256 model.
module tb_sha256_iter_core;

  localparam int RPC = 4;
  localparam int LAT = 64 / RPC + 1;

  localparam logic [255:0] IV_D =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
  localparam logic [511:0] M1_B = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2_B = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_block = '0;
  logic         in_first = 1'b0;
  logic         in_dbl = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] out_digest;
  logic         busy;

  int           total = 0;
  int           bad = 0;
  logic [255:0] model_h = IV_D;

  sha256_iter_core #(.RPC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_first   (in_first),
`ifdef SHA256_DOUBLE_EN
    .in_dbl     (in_dbl),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digest (out_digest),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word expansion, then 64 rounds.
  function automatic logic [255:0] ref_compress(logic [255:0] hin, logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom();
    return b;
  endfunction

  // Offer one block, check latency and digest against the model, hold the
  // digest for 'hold' cycles with in_valid noise, then release it.
  task automatic run_block(input logic [511:0] blk, input logic first, input int hold,
                           input string tag, output logic [255:0] got);
    int n;
    logic [255:0] exp;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    check_val({tag, "_ready"}, 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    in_block = blk;
    in_first = first;
    tick();
    in_valid = 1'b0;
    in_block = rand_block();
    in_first = 1'($urandom_range(0, 1));
    check_val({tag, "_busy"}, 256'(busy), 256'(1));
    n = 0;
    while (!out_valid && n < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_block  = rand_block();
      tick();
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val({tag, "_latency"}, 256'(n), 256'(LAT));
    if (first) model_h = IV_D;
    exp = ref_compress(model_h, blk);
    model_h = exp;
    got = out_digest;
    check_val({tag, "_digest"}, out_digest, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_block = rand_block();
      in_first = 1'($urandom_range(0, 1));
      tick();
      check_val({tag, "_hold_valid"}, 256'(out_valid), 256'(1));
      check_val({tag, "_hold_digest"}, out_digest, exp);
      check_val({tag, "_hold_ready"}, 256'(in_ready), 256'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, "_rel_valid"}, 256'(out_valid), 256'(0));
    check_val({tag, "_rel_ready"}, 256'(in_ready), 256'(1));
    check_val({tag, "_rel_busy"}, 256'(busy), 256'(0));
    $display("blk %s first=%0d lat=%0d hold=%0d digest=%h", tag, first, n, hold, got);
  endtask

  initial begin
    logic [255:0] d;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rst_ready", 256'(in_ready), 256'(1));
    check_val("rst_valid", 256'(out_valid), 256'(0));
    check_val("rst_busy", 256'(busy), 256'(0));
    check_val("rst_digest", out_digest, IV_D);

    run_block(ABC_B, 1'b1, 0, "abc", d);
    check_val("abc_kat", d, ABC_D);
    run_block(EMPTY_B, 1'b1, 0, "empty", d);
    check_val("empty_kat", d, EMPTY_D);
    run_block(M1_B, 1'b1, 0, "two_a", d);
    run_block(M2_B, 1'b0, 0, "two_b", d);
    check_val("two_kat", d, TWO_D);

    run_block(rand_block(), 1'b1, 20, "bp", d);

    // Reset in the middle of a run, roughly round 30.
    in_valid = 1'b1;
    in_block = ABC_B;
    in_first = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30 / RPC) tick();
    check_val("mid_busy", 256'(busy), 256'(1));
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 256'(out_valid), 256'(0));
    check_val("arst_busy", 256'(busy), 256'(0));
    check_val("arst_digest", out_digest, IV_D);
    tick();
    rst = 1'b0;
    #1;
    check_val("arst_ready", 256'(in_ready), 256'(1));
    model_h = IV_D;

    // Continuation right after reset chains from IV.
    run_block(rand_block(), 1'b0, 1, "post_rst", d);
    run_block(ABC_B, 1'b1, 0, "abc2", d);
    check_val("abc2_kat", d, ABC_D);

    for (int i = 0; i < 8; i++) begin
      run_block(rand_block(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d", i), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
